// File: rtl/imem_stream_loader.sv
// ---------------------------------------------------------------------------
// imem_stream_loader
//
// Instruction-memory responder for the LEGLite CPU. The CPU fetches from an
// internal array of 16-bit words. A byte-stream valid/ready port fills the
// array. While a load is in progress the CPU is held in reset. It is released
// when the last word has been written.
//
// Stream format: a 16-bit big-endian word count N, then N words. Each word is
// sent high byte first. Words beyond DEPTH are consumed but discarded.
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-low
//   imemaddr     CPU fetch byte address (bit 0 ignored)
//   imemrdata    combinational instruction word (0 unless in RUN and in range)
//   ld_data      load stream byte
//   ld_valid     ld_data valid
//   ld_ready     byte accepted this cycle (1 in every state except RUN)
//   ld_start     single-cycle reload request, honoured only in RUN
//   cpu_reset    registered active-high reset to the CPU
//   ld_busy      load FSM not in RUN
//   ld_done      sticky: the last load completed
//   ld_error     sticky: the last header count exceeded DEPTH
//   words_loaded words written by the current/last load, saturating at DEPTH
// ---------------------------------------------------------------------------
module imem_stream_loader #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   imemaddr,
  output logic [15:0]   imemrdata,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic          ld_start,
  output logic          cpu_reset,
  output logic          ld_busy,
  output logic          ld_done,
  output logic          ld_error,
  output logic [AW:0]   words_loaded
);

  localparam logic [2:0] S_HDR_HI = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_DAT_HI = 3'd2;
  localparam logic [2:0] S_DAT_LO = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  localparam logic [AW:0] L_DEPTH   = (AW + 1)'(DEPTH);
  localparam logic [15:0] L_DEPTH16 = 16'(DEPTH);

  logic [2:0]  r_state;
  logic [15:0] r_n;          // header word count
  logic [15:0] r_rcv;        // words received so far, including discarded ones
  logic [7:0]  r_hi;         // latched high byte of the word in flight
  logic [AW:0] r_ptr;        // write pointer; doubles as words_loaded
  logic        r_cpu_reset;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_mem [DEPTH];

  logic [2:0]  w_next_state;
  logic        w_xfer;
  logic [15:0] w_hdr_n;
  logic        w_last_word;
  logic        w_ptr_in_range;
  logic        w_addr_in_range;
  logic        w_unused_addr_lsb;

  assign ld_ready     = (r_state != S_RUN);
  assign ld_busy      = (r_state != S_RUN);
  assign cpu_reset    = r_cpu_reset;
  assign ld_done      = r_done;
  assign ld_error     = r_error;
  assign words_loaded = r_ptr;

  assign w_xfer         = ld_valid & ld_ready;
  // Full header count as it will be once the low byte lands this cycle.
  assign w_hdr_n        = {r_n[15:8], ld_data};
  assign w_last_word    = ((r_rcv + 16'd1) == r_n);
  assign w_ptr_in_range = (r_ptr < L_DEPTH);

  // Byte lane of a 16-bit instruction fetch carries no information here.
  assign w_unused_addr_lsb = imemaddr[0];

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_HDR_HI: if (w_xfer) w_next_state = S_HDR_LO;
      S_HDR_LO: if (w_xfer) w_next_state = (w_hdr_n == 16'd0) ? S_RUN : S_DAT_HI;
      S_DAT_HI: if (w_xfer) w_next_state = S_DAT_LO;
      S_DAT_LO: if (w_xfer) w_next_state = w_last_word ? S_RUN : S_DAT_HI;
      S_RUN:    if (ld_start) w_next_state = S_HDR_HI;
      default:  w_next_state = S_HDR_HI;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_HDR_HI;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_n         <= 16'd0;
      r_rcv       <= 16'd0;
      r_hi        <= 8'd0;
      r_ptr       <= '0;
    end else begin
      r_state     <= w_next_state;
      // Registered from the next state so the CPU enters reset on the very
      // edge that leaves RUN and is released on the edge that enters it.
      r_cpu_reset <= (w_next_state != S_RUN);
      case (r_state)
        S_HDR_HI: if (w_xfer) r_n[15:8] <= ld_data;
        S_HDR_LO: begin
          if (w_xfer) begin
            r_n[7:0] <= ld_data;
            if (w_hdr_n == 16'd0)      r_done  <= 1'b1;
            if (w_hdr_n > L_DEPTH16)   r_error <= 1'b1;
          end
        end
        S_DAT_HI: if (w_xfer) r_hi <= ld_data;
        S_DAT_LO: begin
          if (w_xfer) begin
            if (w_ptr_in_range) r_ptr <= r_ptr + 1'b1;
            r_rcv <= r_rcv + 16'd1;
            if (w_last_word) r_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (ld_start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_ptr   <= '0;
            r_n     <= 16'd0;
            r_rcv   <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the word array has no reset; program contents must survive both
  // reset and reloads, and a reset port would block RAM inference.
  always_ff @(posedge clock) begin
    if (reset && (r_state == S_DAT_LO) && w_xfer && w_ptr_in_range)
      r_mem[r_ptr[AW-1:0]] <= {r_hi, ld_data};
  end

  assign w_addr_in_range = (imemaddr[15:AW+1] == '0);
  assign imemrdata = ((r_state == S_RUN) && w_addr_in_range) ?
                     r_mem[imemaddr[AW:1]] : 16'h0000;

endmodule

// File: tb/tb_imem_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_stream_loader
//
// Drives load streams into imem_stream_loader and compares status outputs and
// instruction readback against a word-array model of what each load should
// leave behind. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_imem_stream_loader;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   imemaddr;
  logic [15:0]   imemrdata;
  logic [7:0]    ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_start;
  logic          cpu_reset;
  logic          ld_busy;
  logic          ld_done;
  logic          ld_error;
  logic [AW:0]   words_loaded;

  always #5 clock = ~clock;

  imem_stream_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .imemaddr     (imemaddr),
    .imemrdata    (imemrdata),
    .ld_data      (ld_data),
    .ld_valid     (ld_valid),
    .ld_ready     (ld_ready),
    .ld_start     (ld_start),
    .cpu_reset    (cpu_reset),
    .ld_busy      (ld_busy),
    .ld_done      (ld_done),
    .ld_error     (ld_error),
    .words_loaded (words_loaded)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: what the array and status should hold.
  logic [15:0] exp_mem   [DEPTH];
  bit          exp_known [DEPTH];
  int          exp_words;
  bit          exp_err;

  logic [7:0]  stream_q[$];
  logic [15:0] words_q[$];

  // Build a load of n words: random payload unless fixed words were queued.
  task automatic make_load(input int n, input bit use_given);
    logic [15:0] n16;
    n16 = 16'(n);
    if (!use_given) begin
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
    end
    stream_q.delete();
    stream_q.push_back(n16[15:8]);
    stream_q.push_back(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      stream_q.push_back(words_q[i][15:8]);
      stream_q.push_back(words_q[i][7:0]);
    end
  endtask

  // Effect of a completed load of n words on the model.
  task automatic model_load(input int n);
    for (int i = 0; i < n && i < DEPTH; i++) begin
      exp_mem[i]   = words_q[i];
      exp_known[i] = 1'b1;
    end
    exp_words = (n > DEPTH) ? DEPTH : n;
    exp_err   = (n > DEPTH);
  endtask

  // Send stream_q[first..last-1]; gap idle cycles between bytes (-1: random).
  task automatic send_range(input int first, input int last, input int gap);
    int g;
    for (int i = first; i < last; i++) begin
      ld_data  = stream_q[i];
      ld_valid = 1'b1;
      n_vec++;
      if (ld_ready !== 1'b1) begin
        n_miss++;
        $display("FAIL ready_before_byte idx=%0d got=%b want=1", i, ld_ready);
      end
      @(negedge clock);
      ld_valid = 1'b0;
      ld_data  = 8'($urandom);
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i != stream_q.size() - 1) begin
        repeat (g) begin
          n_vec++;
          if (ld_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL ready_in_gap idx=%0d got=%b want=1", i, ld_ready);
          end
          @(negedge clock);
        end
      end
    end
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(negedge clock);
    ld_start = 1'b0;
  endtask

  // Completed-load status plus full readback against the model.
  task automatic test_readback(input string tag);
    logic [15:0] a;
    n_vec++;
    if ({ld_busy, cpu_reset, ld_done, ld_error} !== {1'b0, 1'b0, 1'b1, exp_err}) begin
      n_miss++;
      $display("FAIL %s_status busy/cpurst/done/err got=%b%b%b%b want=001%b",
               tag, ld_busy, cpu_reset, ld_done, ld_error, exp_err);
    end
    n_vec++;
    if (words_loaded !== 8'(exp_words)) begin
      n_miss++;
      $display("FAIL %s_words got=%0d want=%0d", tag, words_loaded, exp_words);
    end
    for (int i = 0; i < DEPTH; i++) begin
      a = 16'(i * 2) | 16'($urandom_range(0, 1));
      imemaddr = a;
      @(negedge clock);
      if (exp_known[i]) begin
        n_vec++;
        if (imemrdata !== exp_mem[i]) begin
          n_miss++;
          $display("FAIL %s_read addr=%h got=%h want=%h", tag, a, imemrdata, exp_mem[i]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 16'h0100 : 16'($urandom_range(256, 65535));
      imemaddr = a;
      @(negedge clock);
      n_vec++;
      if (imemrdata !== 16'h0000) begin
        n_miss++;
        $display("FAIL %s_oob_read addr=%h got=%h want=0000", tag, a, imemrdata);
      end
    end
    imemaddr = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    n_vec++;
    if ({cpu_reset, ld_busy, ld_ready, ld_done, ld_error} !== 5'b11100) begin
      n_miss++;
      $display("FAIL reset_flags cpurst/busy/ready/done/err got=%b%b%b%b%b want=11100",
               cpu_reset, ld_busy, ld_ready, ld_done, ld_error);
    end
    n_vec++;
    if (words_loaded !== '0 || imemrdata !== 16'h0000) begin
      n_miss++;
      $display("FAIL reset_words_rdata got=%0d/%h want=0/0000", words_loaded, imemrdata);
    end
  endtask

  task automatic test_preload();
    make_load(DEPTH, 1'b0);
    send_range(0, stream_q.size(), 0);
    model_load(DEPTH);
    test_readback("preload");
  endtask

  task automatic test_basic(input int gap, input string tag);
    pulse_start();
    words_q.delete();
    words_q.push_back(16'hCC7B);
    words_q.push_back(16'hCD7B);
    words_q.push_back(16'h000C);
    make_load(3, 1'b1);
    send_range(0, 7, gap);
    repeat (gap) @(negedge clock);
    n_vec++;
    if (cpu_reset !== 1'b1) begin
      n_miss++;
      $display("FAIL %s_cpurst_before_last got=%b want=1", tag, cpu_reset);
    end
    send_range(7, 8, 0);
    model_load(3);
    test_readback(tag);
  endtask

  task automatic test_zero_load();
    pulse_start();
    make_load(0, 1'b0);
    send_range(0, 2, 0);
    model_load(0);
    test_readback("zero");
  endtask

  task automatic test_overflow();
    pulse_start();
    make_load(DEPTH + 2, 1'b0);
    send_range(0, 2, 0);
    n_vec++;
    if (ld_error !== 1'b1 || ld_busy !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_hdr err/busy got=%b%b want=11", ld_error, ld_busy);
    end
    send_range(2, stream_q.size() - 1, 0);
    n_vec++;
    if (ld_busy !== 1'b1 || cpu_reset !== 1'b1 || ld_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_before_last busy/cpurst/ready got=%b%b%b want=111",
               ld_busy, cpu_reset, ld_ready);
    end
    send_range(stream_q.size() - 1, stream_q.size(), 0);
    model_load(DEPTH + 2);
    test_readback("overflow");
  endtask

  task automatic test_reset_midload();
    pulse_start();
    make_load(4, 1'b0);
    send_range(0, 5, 0);
    // Word 0 is complete and stays; word 1 is half-received and is lost.
    exp_mem[0]   = words_q[0];
    exp_known[0] = 1'b1;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n_vec++;
    if ({cpu_reset, ld_busy, ld_ready, ld_done, ld_error} !== 5'b11100 ||
        words_loaded !== '0) begin
      n_miss++;
      $display("FAIL midrst_flags cpurst/busy/ready/done/err got=%b%b%b%b%b words=%0d want=11100 0",
               cpu_reset, ld_busy, ld_ready, ld_done, ld_error, words_loaded);
    end
    make_load(1, 1'b0);
    send_range(0, stream_q.size(), 1);
    model_load(1);
    test_readback("midrst");
  endtask

  task automatic test_start_collision();
    imemaddr = 16'h0000;
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    @(negedge clock);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    n_vec++;
    if ({cpu_reset, ld_ready, ld_done, ld_error} !== 4'b1100 || imemrdata !== 16'h0000 ||
        words_loaded !== '0) begin
      n_miss++;
      $display("FAIL collide cpurst/ready/done/err got=%b%b%b%b rdata=%h words=%0d want=1100 0000 0",
               cpu_reset, ld_ready, ld_done, ld_error, imemrdata, words_loaded);
    end
    // Had 0x55 been consumed as the count high byte, this would not finish.
    words_q.delete();
    words_q.push_back(16'h1234);
    make_load(1, 1'b1);
    send_range(0, stream_q.size(), 0);
    model_load(1);
    test_readback("collide");
  endtask

  task automatic test_random_loads();
    int n;
    for (int t = 0; t < 6; t++) begin
      pulse_start();
      n = int'($urandom_range(0, 40));
      make_load(n, 1'b0);
      send_range(0, stream_q.size(), -1);
      model_load(n);
      test_readback("random");
    end
  endtask

  initial begin
    reset    = 1'b0;
    imemaddr = 16'h0000;
    ld_data  = 8'h00;
    ld_valid = 1'b0;
    ld_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;
    exp_words = 0;
    exp_err   = 1'b0;
    @(negedge clock);

    test_reset();
    test_preload();
    test_basic(0, "basic");
    test_basic(3, "gapped");
    test_zero_load();
    test_overflow();
    test_reset_midload();
    test_start_collision();
    test_random_loads();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
